// File: rtl/mem_arbiter.sv
// Three-way arbiter (loader / CPU / PPU) in front of the single byte-wide PSRAM controller.
// Single-cycle strobes are parked in per-requester slots and replayed through the strobe/busy handshake.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 2,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        ld_wr,
  input  logic [21:0] ld_addr,
  input  logic [7:0]  ld_data,
  output logic        ld_done,

  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [21:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_done,

  input  logic        ppu_rd,
  input  logic [21:0] ppu_addr,
  output logic [7:0]  ppu_rdata,
  output logic        ppu_done,

  output logic        mc_read_a,
  output logic        mc_read_b,
  output logic        mc_write,
  output logic [23:0] mc_addr,
  output logic [7:0]  mc_din,
  input  logic        mc_busy,
  input  logic [7:0]  mc_dout_a,
  input  logic [7:0]  mc_dout_b,

  input  logic        ovf_clr,
  output logic [2:0]  overflow,
  output logic        timeout_err
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  localparam logic [1:0] REQ_LD  = 2'd0;
  localparam logic [1:0] REQ_CPU = 2'd1;
  localparam logic [1:0] REQ_PPU = 2'd2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      grant_q, grant_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [SW-1:0]   starve_q, starve_d;

  logic [2:0]      pend_q, pend_d;
  logic [21:0]     ld_addr_q, ld_addr_d;
  logic [7:0]      ld_data_q, ld_data_d;
  logic [21:0]     cpu_addr_q, cpu_addr_d;
  logic [7:0]      cpu_data_q, cpu_data_d;
  logic            cpu_wr_q, cpu_wr_d;
  logic [21:0]     ppu_addr_q, ppu_addr_d;

  logic            mc_read_a_q, mc_read_a_d;
  logic            mc_read_b_q, mc_read_b_d;
  logic            mc_write_q, mc_write_d;
  logic [23:0]     mc_addr_q, mc_addr_d;
  logic [7:0]      mc_din_q, mc_din_d;

  logic [2:0]      done_q, done_d;
  logic [7:0]      cpu_rdata_q, cpu_rdata_d;
  logic [7:0]      ppu_rdata_q, ppu_rdata_d;
  logic [2:0]      ovf_q, ovf_d;
  logic            timeout_q, timeout_d;

  logic [1:0]      sel;
  logic [2:0]      retire;
  logic [2:0]      drop;
  logic            timeout_hit;
  logic            cpu_req;

  assign cpu_req = cpu_rd | cpu_wr;

  // CPU forced once it has been passed over STARVE_LIMIT times, else loader > PPU > CPU.
  always_comb begin
    sel = REQ_CPU;
    if ((starve_q == SW'(STARVE_LIMIT)) && pend_q[REQ_CPU]) begin
      sel = REQ_CPU;
    end else if (pend_q[REQ_LD]) begin
      sel = REQ_LD;
    end else if (pend_q[REQ_PPU]) begin
      sel = REQ_PPU;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    timer_d     = timer_q;
    starve_d    = starve_q;
    mc_read_a_d = 1'b0;
    mc_read_b_d = 1'b0;
    mc_write_d  = 1'b0;
    mc_addr_d   = mc_addr_q;
    mc_din_d    = mc_din_q;
    done_d      = 3'b000;
    cpu_rdata_d = cpu_rdata_q;
    ppu_rdata_d = ppu_rdata_q;
    retire      = 3'b000;
    timeout_hit = 1'b0;

    case (state_q)
      IDLE: begin
        if ((|pend_q) && !mc_busy) begin
          grant_d = sel;
          timer_d = TW'(BUSY_TIMEOUT - 1);
          state_d = WAIT_BUSY;
          case (sel)
            REQ_LD: begin
              mc_write_d = 1'b1;
              mc_addr_d  = {2'b00, ld_addr_q};
              mc_din_d   = ld_data_q;
            end
            REQ_PPU: begin
              mc_read_b_d = 1'b1;
              mc_addr_d   = {2'b00, ppu_addr_q};
            end
            default: begin
              mc_write_d  = cpu_wr_q;
              mc_read_a_d = !cpu_wr_q;
              mc_addr_d   = {2'b00, cpu_addr_q};
              mc_din_d    = cpu_data_q;
            end
          endcase
          if (sel == REQ_CPU) begin
            starve_d = '0;
          end else if (pend_q[REQ_CPU] && (starve_q != SW'(STARVE_LIMIT))) begin
            starve_d = starve_q + 1'b1;
          end
        end
      end

      WAIT_BUSY: begin
        if (mc_busy) begin
          state_d = WAIT_DONE;
        end else if (timer_q == '0) begin
          // Slot stays pending so the access is simply retried from IDLE.
          timeout_hit = 1'b1;
          state_d     = IDLE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      WAIT_DONE: begin
        if (!mc_busy) begin
          done_d[grant_q] = 1'b1;
          retire[grant_q] = 1'b1;
          state_d         = IDLE;
          if ((grant_q == REQ_CPU) && !cpu_wr_q) begin
            cpu_rdata_d = mc_dout_a;
          end
          if (grant_q == REQ_PPU) begin
            ppu_rdata_d = mc_dout_b;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // A slot retiring on this edge counts as empty, so a strobe coincident with done is kept.
  always_comb begin
    pend_d     = pend_q & ~retire;
    ld_addr_d  = ld_addr_q;
    ld_data_d  = ld_data_q;
    cpu_addr_d = cpu_addr_q;
    cpu_data_d = cpu_data_q;
    cpu_wr_d   = cpu_wr_q;
    ppu_addr_d = ppu_addr_q;
    drop       = 3'b000;

    if (ld_wr) begin
      if (!pend_d[REQ_LD]) begin
        pend_d[REQ_LD] = 1'b1;
        ld_addr_d      = ld_addr;
        ld_data_d      = ld_data;
      end else begin
        drop[REQ_LD] = 1'b1;
      end
    end

    if (cpu_req) begin
      if (!pend_d[REQ_CPU]) begin
        pend_d[REQ_CPU] = 1'b1;
        cpu_addr_d      = cpu_addr;
        cpu_data_d      = cpu_wdata;
        cpu_wr_d        = cpu_wr;
      end else begin
        drop[REQ_CPU] = 1'b1;
      end
    end

    if (ppu_rd) begin
      if (!pend_d[REQ_PPU]) begin
        pend_d[REQ_PPU] = 1'b1;
        ppu_addr_d      = ppu_addr;
      end else begin
        drop[REQ_PPU] = 1'b1;
      end
    end
  end

  // Clear first, then set, so an event on the clearing edge survives.
  always_comb begin
    ovf_d     = (ovf_clr ? 3'b000 : ovf_q) | drop;
    timeout_d = (ovf_clr ? 1'b0 : timeout_q) | timeout_hit;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= REQ_LD;
      timer_q     <= '0;
      starve_q    <= '0;
      pend_q      <= 3'b000;
      ld_addr_q   <= '0;
      ld_data_q   <= '0;
      cpu_addr_q  <= '0;
      cpu_data_q  <= '0;
      cpu_wr_q    <= 1'b0;
      ppu_addr_q  <= '0;
      mc_read_a_q <= 1'b0;
      mc_read_b_q <= 1'b0;
      mc_write_q  <= 1'b0;
      mc_addr_q   <= '0;
      mc_din_q    <= '0;
      done_q      <= 3'b000;
      cpu_rdata_q <= '0;
      ppu_rdata_q <= '0;
      ovf_q       <= 3'b000;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      timer_q     <= timer_d;
      starve_q    <= starve_d;
      pend_q      <= pend_d;
      ld_addr_q   <= ld_addr_d;
      ld_data_q   <= ld_data_d;
      cpu_addr_q  <= cpu_addr_d;
      cpu_data_q  <= cpu_data_d;
      cpu_wr_q    <= cpu_wr_d;
      ppu_addr_q  <= ppu_addr_d;
      mc_read_a_q <= mc_read_a_d;
      mc_read_b_q <= mc_read_b_d;
      mc_write_q  <= mc_write_d;
      mc_addr_q   <= mc_addr_d;
      mc_din_q    <= mc_din_d;
      done_q      <= done_d;
      cpu_rdata_q <= cpu_rdata_d;
      ppu_rdata_q <= ppu_rdata_d;
      ovf_q       <= ovf_d;
      timeout_q   <= timeout_d;
    end
  end

  assign ld_done     = done_q[REQ_LD];
  assign cpu_done    = done_q[REQ_CPU];
  assign ppu_done    = done_q[REQ_PPU];
  assign cpu_rdata   = cpu_rdata_q;
  assign ppu_rdata   = ppu_rdata_q;
  assign mc_read_a   = mc_read_a_q;
  assign mc_read_b   = mc_read_b_q;
  assign mc_write    = mc_write_q;
  assign mc_addr     = mc_addr_q;
  assign mc_din      = mc_din_q;
  assign overflow    = ovf_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, random traffic against a transaction-level
// model, and hand sequences for starvation, overflow, timeout and mid-operation reset.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ld_wr = 1'b0;
  logic [21:0] ld_addr = '0;
  logic [7:0]  ld_data = '0;
  logic        ld_done;
  logic        cpu_rd = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [21:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic [7:0]  cpu_rdata;
  logic        cpu_done;
  logic        ppu_rd = 1'b0;
  logic [21:0] ppu_addr = '0;
  logic [7:0]  ppu_rdata;
  logic        ppu_done;
  logic        mc_read_a, mc_read_b, mc_write;
  logic [23:0] mc_addr;
  logic [7:0]  mc_din;
  logic        mc_busy = 1'b0;
  logic [7:0]  mc_dout_a = '0;
  logic [7:0]  mc_dout_b = '0;
  logic        ovf_clr = 1'b0;
  logic [2:0]  overflow;
  logic        timeout_err;

  int n_cmp = 0;
  int n_err = 0;

  // 0: nominal (busy 3 cycles, 1 cycle after strobe), 1: never busy, 2: stuck busy
  int mode = 0;
  int bcnt = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_LIMIT(2), .BUSY_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .ld_wr(ld_wr), .ld_addr(ld_addr), .ld_data(ld_data), .ld_done(ld_done),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
    .ppu_rd(ppu_rd), .ppu_addr(ppu_addr), .ppu_rdata(ppu_rdata), .ppu_done(ppu_done),
    .mc_read_a(mc_read_a), .mc_read_b(mc_read_b), .mc_write(mc_write),
    .mc_addr(mc_addr), .mc_din(mc_din), .mc_busy(mc_busy),
    .mc_dout_a(mc_dout_a), .mc_dout_b(mc_dout_b),
    .ovf_clr(ovf_clr), .overflow(overflow), .timeout_err(timeout_err)
  );

  // Controller model: read data is a fixed function of the strobed address.
  always @(posedge clk) begin
    if (mc_read_a) mc_dout_a <= mc_addr[7:0] ^ 8'h86;
    if (mc_read_b) mc_dout_b <= mc_addr[7:0] ^ 8'h3C;
    if (mode == 1) begin
      mc_busy <= 1'b0;
      bcnt    <= 0;
    end else if (mode == 2) begin
      mc_busy <= 1'b1;
      bcnt    <= 0;
    end else if (mc_read_a || mc_read_b || mc_write) begin
      mc_busy <= 1'b1;
      bcnt    <= 3;
    end else if (bcnt != 0) begin
      mc_busy <= (bcnt > 1);
      bcnt    <= bcnt - 1;
    end else begin
      mc_busy <= 1'b0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_in();
    ld_wr = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0; ppu_rd = 1'b0; ovf_clr = 1'b0;
  endtask

  task automatic reset_dut();
    clear_in();
    reset = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic drive_req(input int kind, input logic [21:0] a, input logic [7:0] d);
    case (kind)
      0: begin ld_wr = 1'b1; ld_addr = a; ld_data = d; end
      1: begin cpu_rd = 1'b1; cpu_addr = a; cpu_wdata = d; end
      2: begin cpu_wr = 1'b1; cpu_addr = a; cpu_wdata = d; end
      3: begin cpu_rd = 1'b1; cpu_wr = 1'b1; cpu_addr = a; cpu_wdata = d; end
      default: begin ppu_rd = 1'b1; ppu_addr = a; end
    endcase
  endtask

  task automatic wait_cpu_done(input string name, input int limit);
    int t = 0;
    while (!cpu_done && t < limit) begin tick(); t++; end
    check(name, 32'(cpu_done), 32'd1);
  endtask

  typedef struct {
    int         kind;
    logic [21:0] addr;
    logic [7:0] wdata;
    logic [2:0] exp_strobe;   // {read_a, read_b, write}
    logic [2:0] exp_done;     // {ppu, cpu, ld}
    logic [7:0] exp_crd;
    logic [7:0] exp_prd;
  } vec_t;

  task automatic run_table();
    vec_t tbl[6];
    int lat;
    tbl[0] = '{1, 22'h000123, 8'h00, 3'b100, 3'b010, 8'hA5, 8'h00};
    tbl[1] = '{2, 22'h3FFFFF, 8'h5C, 3'b001, 3'b010, 8'hA5, 8'h00};
    tbl[2] = '{0, 22'h000000, 8'hFF, 3'b001, 3'b001, 8'hA5, 8'h00};
    tbl[3] = '{4, 22'h2ABCDE, 8'h00, 3'b010, 3'b100, 8'hA5, 8'hE2};
    tbl[4] = '{3, 22'h001000, 8'h11, 3'b001, 3'b010, 8'hA5, 8'hE2};
    tbl[5] = '{1, 22'h3FFF80, 8'h00, 3'b100, 3'b010, 8'h06, 8'hE2};
    for (int i = 0; i < 6; i++) begin
      drive_req(tbl[i].kind, tbl[i].addr, tbl[i].wdata);
      tick();
      clear_in();
      tick();
      check("tbl_strobe", 32'({mc_read_a, mc_read_b, mc_write}), 32'(tbl[i].exp_strobe));
      check("tbl_addr", 32'(mc_addr), 32'({2'b00, tbl[i].addr}));
      if (tbl[i].exp_strobe[0]) check("tbl_din", 32'(mc_din), 32'(tbl[i].wdata));
      lat = 1;
      while (lat < 20 && {ppu_done, cpu_done, ld_done} == 3'b000) begin tick(); lat++; end
      check("tbl_latency", lat, 6);
      check("tbl_done", 32'({ppu_done, cpu_done, ld_done}), 32'(tbl[i].exp_done));
      check("tbl_cpu_rdata", 32'(cpu_rdata), 32'(tbl[i].exp_crd));
      check("tbl_ppu_rdata", 32'(ppu_rdata), 32'(tbl[i].exp_prd));
      check("tbl_overflow", 32'(overflow), 32'd0);
      tick(); tick();
    end
  endtask

  // Transaction-level reference: each grant occupies the memory for 6 edges
  // (done after grant+5, next grant no earlier than grant+6) with the nominal controller.
  task automatic run_random(input int ncyc);
    bit          pend[3];
    logic [21:0] maddr[3];
    logic [7:0]  mdata[3];
    logic [21:0] in_addr[3];
    logic [7:0]  in_data[3];
    bit          mcpu_wr = 1'b0;
    int          act = -1, rem = 0, starve = 0, retire, g;
    logic [2:0]  e_done, e_strobe, e_ovf, strb;
    logic [23:0] e_addr = '0;
    logic [7:0]  e_din = '0, e_crd = '0, e_prd = '0;
    e_ovf = 3'b000;
    for (int r = 0; r < 3; r++) begin pend[r] = 1'b0; maddr[r] = '0; mdata[r] = '0; end
    for (int c = 0; c < ncyc; c++) begin
      ld_wr     = ($urandom_range(0, 99) < 12);
      cpu_rd    = ($urandom_range(0, 99) < 10);
      cpu_wr    = ($urandom_range(0, 99) < 10);
      ppu_rd    = ($urandom_range(0, 99) < 12);
      ovf_clr   = ($urandom_range(0, 99) < 3);
      ld_addr   = 22'($urandom);
      ld_data   = 8'($urandom);
      cpu_addr  = 22'($urandom);
      cpu_wdata = 8'($urandom);
      ppu_addr  = 22'($urandom);
      strb = {ppu_rd, cpu_rd | cpu_wr, ld_wr};
      in_addr[0] = ld_addr;  in_data[0] = ld_data;
      in_addr[1] = cpu_addr; in_data[1] = cpu_wdata;
      in_addr[2] = ppu_addr; in_data[2] = 8'h00;

      e_done = 3'b000; e_strobe = 3'b000; retire = -1;
      if (act >= 0) begin
        rem--;
        if (rem == 0) begin
          retire = act;
          e_done[act] = 1'b1;
          if (act == 1 && !mcpu_wr) e_crd = maddr[1][7:0] ^ 8'h86;
          if (act == 2) e_prd = maddr[2][7:0] ^ 8'h3C;
          act = -1;
        end
      end else if (pend[0] || pend[1] || pend[2]) begin
        if (starve == 2 && pend[1]) g = 1;
        else if (pend[0]) g = 0;
        else if (pend[2]) g = 2;
        else g = 1;
        if (g == 1) starve = 0;
        else if (pend[1] && starve < 2) starve++;
        e_addr = {2'b00, maddr[g]};
        e_din  = mdata[g];
        e_strobe = (g == 0) ? 3'b001 : (g == 2) ? 3'b010 : (mcpu_wr ? 3'b001 : 3'b100);
        act = g;
        rem = 5;
      end
      if (retire >= 0) pend[retire] = 1'b0;
      if (ovf_clr) e_ovf = 3'b000;
      for (int r = 0; r < 3; r++) begin
        if (strb[r]) begin
          if (!pend[r]) begin
            pend[r] = 1'b1;
            maddr[r] = in_addr[r];
            mdata[r] = in_data[r];
            if (r == 1) mcpu_wr = cpu_wr;
          end else begin
            e_ovf[r] = 1'b1;
          end
        end
      end

      tick();
      check("rnd_done", 32'({ppu_done, cpu_done, ld_done}), 32'(e_done));
      check("rnd_strobe", 32'({mc_read_a, mc_read_b, mc_write}), 32'(e_strobe));
      if (e_strobe != 3'b000) check("rnd_addr", 32'(mc_addr), 32'(e_addr));
      if (e_strobe[0]) check("rnd_din", 32'(mc_din), 32'(e_din));
      check("rnd_cpu_rdata", 32'(cpu_rdata), 32'(e_crd));
      check("rnd_ppu_rdata", 32'(ppu_rdata), 32'(e_prd));
      check("rnd_overflow", 32'(overflow), 32'(e_ovf));
    end
    clear_in();
  endtask

  task automatic seq_simultaneous();
    int t_ld = -1, t_ppu = -1, t_cpu = -1, multi = 0;
    reset_dut();
    drive_req(0, 22'h000001, 8'h09);
    drive_req(4, 22'h000002, 8'h00);
    drive_req(1, 22'h000003, 8'h00);
    tick();
    clear_in();
    for (int t = 1; t <= 30; t++) begin
      tick();
      if (ld_done && t_ld < 0) t_ld = t;
      if (ppu_done && t_ppu < 0) t_ppu = t;
      if (cpu_done && t_cpu < 0) t_cpu = t;
      if (int'(mc_read_a) + int'(mc_read_b) + int'(mc_write) > 1) multi++;
    end
    check("sim_ld_done_at", t_ld, 6);
    check("sim_ppu_done_at", t_ppu, 12);
    check("sim_cpu_done_at", t_cpu, 18);
    check("sim_one_strobe", multi, 0);
  endtask

  task automatic seq_starve();
    int n_ppu = 0, got = 0, t = 0;
    reset_dut();
    drive_req(1, 22'h000010, 8'h00);
    drive_req(4, 22'h000020, 8'h00);
    tick();
    cpu_rd = 1'b0;     // PPU keeps strobing every cycle
    while (!got && t < 60) begin
      tick(); t++;
      if (ppu_done) n_ppu++;
      if (cpu_done) got = 1;
    end
    check("starve_cpu_granted", got, 1);
    check("starve_ppu_grants", n_ppu, 2);
    ppu_rd = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check("starve_ppu_ovf", 32'(overflow), 32'b100);
    ovf_clr = 1'b1; tick(); clear_in();
    check("starve_ovf_clr", 32'(overflow), 32'd0);
  endtask

  task automatic seq_overflow();
    reset_dut();
    drive_req(2, 22'h000010, 8'h11);
    tick(); clear_in();                                   // E0
    tick();                                               // E1
    check("ovf_first_wr", 32'(mc_write), 32'd1);
    check("ovf_first_addr", 32'(mc_addr), 32'h10);
    check("ovf_first_din", 32'(mc_din), 32'h11);
    drive_req(2, 22'h000020, 8'h22);
    tick(); clear_in();                                   // E2
    check("ovf_flag", 32'(overflow), 32'b010);
    drive_req(2, 22'h000030, 8'h55);
    ovf_clr = 1'b1;
    tick(); clear_in();                                   // E3
    check("ovf_set_wins", 32'(overflow), 32'b010);
    ovf_clr = 1'b1;
    tick(); clear_in();                                   // E4
    check("ovf_cleared", 32'(overflow), 32'd0);
    tick();                                               // E5
    check("ovf_no_early_done", 32'(cpu_done), 32'd0);
    drive_req(2, 22'h000044, 8'h44);
    tick(); clear_in();                                   // E6
    check("ovf_done_edge", 32'(cpu_done), 32'd1);
    check("ovf_same_edge_noflag", 32'(overflow), 32'd0);
    tick();                                               // E7
    check("ovf_next_wr", 32'(mc_write), 32'd1);
    check("ovf_next_addr", 32'(mc_addr), 32'h44);
    check("ovf_next_din", 32'(mc_din), 32'h44);
    wait_cpu_done("ovf_next_done", 15);
  endtask

  task automatic seq_timeout();
    int t = 1;
    reset_dut();
    mode = 1;
    drive_req(1, 22'h000077, 8'h00);
    tick(); clear_in();
    tick();
    check("to_strobe", 32'(mc_read_a), 32'd1);
    while (!timeout_err && t < 15) begin tick(); t++; end
    check("to_cycles_after_strobe", t - 1, 4);
    tick();
    check("to_retry_strobe", 32'(mc_read_a), 32'd1);
    mode = 0;
    wait_cpu_done("to_done_after_fix", 40);
    check("to_rdata", 32'(cpu_rdata), 32'hF1);
    check("to_sticky", 32'(timeout_err), 32'd1);
    ovf_clr = 1'b1; tick(); clear_in();
    check("to_clr", 32'(timeout_err), 32'd0);
  endtask

  task automatic seq_reset();
    int strobes = 0, t = 0;
    reset_dut();
    drive_req(1, 22'h000012, 8'h00);
    tick(); clear_in();
    wait_cpu_done("rst_pre_done", 15);
    check("rst_pre_rdata", 32'(cpu_rdata), 32'h94);
    tick(); tick();
    drive_req(1, 22'h000055, 8'h00);
    tick(); clear_in();                                   // E0
    tick();                                               // E1
    drive_req(1, 22'h000056, 8'h00);
    tick(); clear_in();                                   // E2, dropped
    tick();                                               // E3: in WAIT_DONE, busy high
    mode = 2;
    reset = 1'b1;
    #1;
    check("rst_ctrl_zero", 32'({mc_read_a, mc_read_b, mc_write, ld_done, cpu_done, ppu_done,
                                overflow, timeout_err}), 32'd0);
    check("rst_addr_din_zero", {mc_addr, mc_din}, 32'd0);
    check("rst_rdata_zero", 32'({cpu_rdata, ppu_rdata}), 32'd0);
    @(negedge clk);
    tick();
    reset = 1'b0;
    drive_req(1, 22'h000066, 8'h00);
    tick(); clear_in();
    for (int i = 0; i < 5; i++) begin
      tick();
      if (mc_read_a || mc_read_b || mc_write) strobes++;
    end
    check("rst_no_strobe_while_busy", strobes, 0);
    mode = 0;
    while (!mc_read_a && t < 10) begin tick(); t++; end
    check("rst_strobe_after_idle", 32'(mc_read_a), 32'd1);
    check("rst_strobe_addr", 32'(mc_addr), 32'h66);
    wait_cpu_done("rst_done", 15);
    check("rst_rdata", 32'(cpu_rdata), 32'hE0);
  endtask

  initial begin
    reset_dut();
    check("reset_ctrl", 32'({mc_read_a, mc_read_b, mc_write, ld_done, cpu_done, ppu_done,
                             overflow, timeout_err}), 32'd0);
    check("reset_addr_din", {mc_addr, mc_din}, 32'd0);
    check("reset_rdata", 32'({cpu_rdata, ppu_rdata}), 32'd0);
    run_table();
    reset_dut();
    run_random(800);
    seq_simultaneous();
    seq_starve();
    seq_overflow();
    seq_timeout();
    seq_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single byte-wide PSRAM memory controller between three requesters: game loader (write only), CPU (read/write) and PPU (read only).
- Replaces the ad-hoc OR/mux of loader and NES strobes in the top level.
- Latches single-cycle request strobes into per-requester slots, grants them by priority with a CPU anti-starvation guard, and sequences the controller's strobe/busy handshake.
- Returns read data and a done pulse to each requester.

Parameters:
- STARVE_LIMIT, 2: consecutive non-CPU grants while the CPU is pending before the CPU is forced next.
- BUSY_TIMEOUT, 4: cycles in WAIT_BUSY without mc_busy before aborting.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ld_wr  in  1  loader write strobe (1 cycle)
- ld_addr  in  22  loader address
- ld_data  in  8  loader write data
- ld_done  out  1  loader access complete (1-cycle pulse)
- cpu_rd  in  1  CPU read strobe
- cpu_wr  in  1  CPU write strobe
- cpu_addr  in  22  CPU address
- cpu_wdata  in  8  CPU write data
- cpu_rdata  out  8  CPU read data, valid while cpu_done is high and held afterwards
- cpu_done  out  1  CPU access complete pulse
- ppu_rd  in  1  PPU read strobe
- ppu_addr  in  22  PPU address
- ppu_rdata  out  8  PPU read data, held
- ppu_done  out  1  PPU access complete pulse
- mc_read_a  out  1  controller read strobe, port A (CPU)
- mc_read_b  out  1  controller read strobe, port B (PPU)
- mc_write  out  1  controller write strobe
- mc_addr  out  24  controller address, {2'b00, addr}
- mc_din  out  8  controller write data
- mc_busy  in  1  controller busy
- mc_dout_a  in  8  controller read data, port A
- mc_dout_b  in  8  controller read data, port B
- ovf_clr  in  1  clears sticky flags
- overflow  out  3  sticky strobe-dropped flags {ppu, cpu, ld}
- timeout_err  out  1  sticky flag: mc_busy was never seen

Behaviour:
- Reset (async): all outputs 0, all slots empty, starvation counter 0, state IDLE. cpu_rdata and ppu_rdata reset to 0.
- Slot capture:
  - A strobe is latched (address, data, rd/wr) at the clock edge on which it is high.
  - The slot is accepted if the slot is empty, or is being retired on that same edge. Otherwise the strobe is dropped, the slot is untouched, and overflow bit is set.
  - cpu_rd and cpu_wr together: treated as a write; the read is ignored with no flag.
- Grant priority, evaluated in IDLE only:
  - If the starvation counter equals STARVE_LIMIT and the CPU is pending: CPU.
  - Otherwise: loader > PPU > CPU.
  - The counter increments on each loader/PPU grant while the CPU slot is pending, saturates at STARVE_LIMIT, and clears on a CPU grant.
- FSM (all mc_* outputs registered):
  - IDLE: if any slot is pending and mc_busy == 0, grant. Drive mc_addr/mc_din and exactly one strobe (CPU read→mc_read_a, PPU read→mc_read_b, writes→mc_write) for one cycle. Go to WAIT_BUSY. If mc_busy == 1 (e.g. after reset mid-op), wait.
  - WAIT_BUSY: strobes are 0. When mc_busy == 1, go to WAIT_DONE. If BUSY_TIMEOUT cycles elapse, set timeout_err, keep the slot pending, return to IDLE (retry).
  - WAIT_DONE: when mc_busy == 0, pulse the granted requester's done for 1 cycle. For reads, load rdata from mc_dout_a/b on the same edge. Clear the slot and return to IDLE.
- Latency with a nominal controller (busy high 3 cycles, asserted 1 cycle after the strobe):
  - Strobe at edge E0, mc strobe high after E1, done high after E6: 6 cycles.
  - Back-to-back pending accesses issue every 6 cycles.
- Only one mc strobe is ever high at a time; no strobe is issued while mc_busy == 1.
- ovf_clr clears overflow and timeout_err. A flag set on the same edge as ovf_clr wins (stays set).
- Addresses pass through unmodified (22-bit zero-extended); no wrap logic.

Test Plan:
- Single CPU read, addr 0x000123, with the controller model returning 0xA5 on port A → mc_read_a for 1 cycle, mc_addr 0x000123, cpu_done 6 cycles after the strobe, cpu_rdata 0xA5.
- ld_wr, ppu_rd and cpu_rd strobed on the same edge → grant order loader, PPU, CPU; done pulses at +6, +12, +18.
- Continuous PPU strobes (re-issued on each ppu_done) with the CPU pending, STARVE_LIMIT 2 → the CPU is granted after exactly 2 PPU grants.
- Second cpu_wr while the CPU slot is busy → overflow == 3'b010, the first write completes with its original data. ovf_clr → overflow 0. A strobe on the same edge as cpu_done is accepted with no flag.
- Controller model never raises busy → timeout_err after 4 cycles, the request is retried, and it completes once the model is fixed.
- Assert reset during WAIT_DONE while mc_busy == 1 → all outputs 0 immediately. After release, a new request waits until mc_busy == 0 before issuing.
